// File: rtl/signed_stream_pkg.sv
// Shared types for the signed stream accumulator.
// Provides the controller state encoding used by the top level.
package signed_stream_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/signed_add_sat.sv
// Combinational two's complement adder with overflow flag and optional clamp.
// Ports: a, b (signed operands), sat_en (1 = clamp on overflow),
//        sum (wrapped or clamped result), overflow (step overflowed).
module signed_add_sat #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_en,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_raw;

    assign w_raw = a + b;

    // Overflow only possible when operands share a sign and result flips it
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (w_raw[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        sum = w_raw;
        if (sat_en && overflow) begin
            sum = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/signed_stream_accum_sat.sv
// Packet accumulator: sums signed beats per packet, one result per packet.
// Ports: clk, rst (async active-low), in_* beat stream (valid/ready/data/last,
//        sat_en per beat), out_* result stream (valid/ready/sum/overflow/beats).
module signed_stream_accum_sat
    import signed_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_beats
);

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_acc;
    logic             r_first;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_out_beats;

    logic             w_accept;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_sticky_nx;
    logic [CNT_W-1:0] w_cnt_nx;

    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // First beat of a packet starts from zero rather than the stale acc
    assign w_a = r_first ? '0 : r_acc;

    signed_add_sat #(
        .WIDTH (WIDTH)
    ) u_add (
        .a        (w_a),
        .b        (in_data),
        .sat_en   (sat_en),
        .sum      (w_sum),
        .overflow (w_ovf)
    );

    assign w_sticky_nx = (r_first ? 1'b0 : r_sticky) | w_ovf;
    assign w_cnt_nx    = r_first  ? CNT_W'(1) :
                         (&r_cnt) ? r_cnt     : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ACCUM: if (w_accept && in_last) w_state_nx = HOLD;
            HOLD:  if (w_out_fire)          w_state_nx = ACCUM;
            default: w_state_nx = ACCUM;
        endcase
    end

    // Ready is purely state-derived; masked by reset so it drops immediately
    always_comb begin
        in_ready = (r_state == ACCUM) && rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_first     <= 1'b1;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_beats <= '0;
        end else begin
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_acc    <= w_sum;
                r_sticky <= w_sticky_nx;
                r_cnt    <= w_cnt_nx;
                r_first  <= in_last;
                if (in_last) begin
                    r_out_valid <= 1'b1;
                    r_out_sum   <= w_sum;
                    r_out_ovf   <= w_sticky_nx;
                    r_out_beats <= w_cnt_nx;
                end
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_ovf;
    assign out_beats    = r_out_beats;

endmodule

// File: tb/tb_signed_stream_accum_sat.sv
// Self-checking bench for signed_stream_accum_sat (WIDTH=4, CNT_W=8).
// Directed and random packets compared against an integer reference model.
module tb_signed_stream_accum_sat;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int MAXV = (2 ** (W - 1)) - 1;
    localparam int MINV = -(2 ** (W - 1));
    localparam int CMAX = (2 ** CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          sat_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_overflow;
    logic [CW-1:0] out_beats;

    int n_checks = 0;
    int n_fail   = 0;

    signed_stream_accum_sat #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .sat_en       (sat_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .out_beats    (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mathematical model: exact integer sum per step, then clamp or wrap
    function automatic void model(input int vals[$], input bit sats[$],
                                  output logic [W-1:0] esum,
                                  output bit eovf,
                                  output logic [CW-1:0] ebeats);
        int acc;
        int r;
        int n;
        acc  = 0;
        eovf = 1'b0;
        for (int i = 0; i < vals.size(); i++) begin
            r = ((i == 0) ? 0 : acc) + vals[i];
            if (r > MAXV || r < MINV) begin
                eovf = 1'b1;
                if (sats[i])
                    r = (r > MAXV) ? MAXV : MINV;
                else if (r > MAXV)
                    r = r - (2 ** W);
                else
                    r = r + (2 ** W);
            end
            acc = r;
        end
        esum   = acc[W-1:0];
        n      = vals.size();
        ebeats = (n > CMAX) ? CMAX[CW-1:0] : n[CW-1:0];
    endfunction

    // Drives one packet starting at a negedge; returns outputs seen at the
    // negedge right after the last beat was accepted.
    task automatic drive_packet(input int vals[$], input bit sats[$],
                                output bit vld,
                                output logic [W-1:0] s,
                                output bit o,
                                output logic [CW-1:0] b,
                                output bit tmo);
        int v;
        int w;
        tmo = 1'b0;
        for (int i = 0; i < vals.size(); i++) begin
            v        = vals[i];
            in_valid = 1'b1;
            in_data  = v[W-1:0];
            in_last  = (i == vals.size() - 1);
            sat_en   = sats[i];
            w        = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) tmo = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vld = out_valid;
        s   = out_sum;
        o   = out_overflow;
        b   = out_beats;
    endtask

    int            vq[$];
    bit            sq[$];
    bit            g_vld;
    logic [W-1:0]  g_sum;
    bit            g_ovf;
    logic [CW-1:0] g_beats;
    bit            g_tmo;
    logic [W-1:0]  e_sum;
    bit            e_ovf;
    logic [CW-1:0] e_beats;

    task automatic fill_sat(input bit val);
        sq = {};
        for (int i = 0; i < vq.size(); i++) sq.push_back(val);
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        sat_en    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 ||
            out_overflow !== 1'b0 || out_beats !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got v=%b s=%h o=%b b=%0d r=%b want 0,0,0,0,1",
                     out_valid, out_sum, out_overflow, out_beats, in_ready);
        end
    endtask

    task automatic test_basic;
        vq = '{3, 2, 1};
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        model(vq, sq, e_sum, e_ovf, e_beats);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== e_sum ||
            g_ovf !== e_ovf || g_beats !== e_beats) begin
            n_fail++;
            $display("FAIL basic got v=%b s=%h o=%b b=%0d want 1,%h,%b,%0d",
                     g_vld, g_sum, g_ovf, g_beats, e_sum, e_ovf, e_beats);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_handshake got v=%b r=%b want 0,1", out_valid, in_ready);
        end
    endtask

    task automatic test_wrap;
        vq = '{7, 1};
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== 4'b1000 || g_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_7_1 got s=%h o=%b want 8,1", g_sum, g_ovf);
        end
        @(negedge clk);
        vq = '{7, 1, -1};
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== 4'd7 || g_ovf !== 1'b1 || g_beats !== 8'd3) begin
            n_fail++;
            $display("FAIL wrap_7_1_m1 got s=%h o=%b b=%0d want 7,1,3", g_sum, g_ovf, g_beats);
        end
        @(negedge clk);
    endtask

    task automatic test_sat;
        vq = '{7, 1, 1};
        fill_sat(1'b1);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== 4'd7 || g_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos got s=%h o=%b want 7,1", g_sum, g_ovf);
        end
        @(negedge clk);
        vq = '{-8, -1};
        fill_sat(1'b1);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== 4'b1000 || g_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg got s=%h o=%b want 8,1", g_sum, g_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit bad;
        out_ready = 1'b0;
        vq = '{7, 1};
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'd3;
            in_last  = 1'b1;
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 4'b1000 ||
                out_overflow !== 1'b1 || out_beats !== 8'd2) bad = 1'b1;
        end
        n_checks++;
        if (g_tmo || bad) begin
            n_fail++;
            $display("FAIL backpressure_hold got v=%b r=%b s=%h o=%b b=%0d want 1,0,8,1,2",
                     out_valid, in_ready, out_sum, out_overflow, out_beats);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release got v=%b want 0", out_valid);
        end
        vq = '{2};
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== 4'd2 || g_ovf !== 1'b0 || g_beats !== 8'd1) begin
            n_fail++;
            $display("FAIL backpressure_next got s=%h o=%b b=%0d want 2,0,1", g_sum, g_ovf, g_beats);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1;
        in_last  = 1'b0;
        sat_en   = 1'b0;
        in_data  = 4'd6;
        @(negedge clk);
        in_data  = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_packet got v=%b r=%b want 0,0", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        vq = '{5};
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== 4'd5 || g_ovf !== 1'b0 || g_beats !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_mid_after got s=%h o=%b b=%0d want 5,0,1", g_sum, g_ovf, g_beats);
        end
        @(negedge clk);
        out_ready = 1'b0;
        vq = '{3};
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (g_vld !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold got pre=%b post=%b want 1,0", g_vld, out_valid);
        end
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_boundaries;
        vq = '{-8};
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== 4'b1000 || g_ovf !== 1'b0 || g_beats !== 8'd1) begin
            n_fail++;
            $display("FAIL single_beat got s=%h o=%b b=%0d want 8,0,1", g_sum, g_ovf, g_beats);
        end
        @(negedge clk);
        vq = {};
        for (int i = 0; i < 300; i++) vq.push_back(0);
        fill_sat(1'b0);
        drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
        n_checks++;
        if (g_tmo || g_vld !== 1'b1 || g_sum !== 4'd0 || g_ovf !== 1'b0 || g_beats !== 8'd255) begin
            n_fail++;
            $display("FAIL long_packet got s=%h o=%b b=%0d want 0,0,255", g_sum, g_ovf, g_beats);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int len;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 6);
            vq  = {};
            sq  = {};
            for (int i = 0; i < len; i++) begin
                vq.push_back($urandom_range(0, 15) - 8);
                sq.push_back(1'($urandom_range(0, 1)));
            end
            drive_packet(vq, sq, g_vld, g_sum, g_ovf, g_beats, g_tmo);
            model(vq, sq, e_sum, e_ovf, e_beats);
            n_checks++;
            if (g_tmo || g_vld !== 1'b1 || g_sum !== e_sum ||
                g_ovf !== e_ovf || g_beats !== e_beats) begin
                n_fail++;
                $display("FAIL random_pkt%0d got s=%h o=%b b=%0d want %h,%b,%0d",
                         p, g_sum, g_ovf, g_beats, e_sum, e_ovf, e_beats);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_sat();
        test_backpressure();
        test_reset_mid();
        test_boundaries();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_stream_accum_sat.md
Name: signed_stream_accum_sat

Overview:
Streaming signed (two's complement) accumulator with per-step overflow detection and optional saturation, parametrised in width. Consumes a packet of signed beats over a valid/ready input and returns one result per packet (sum, sticky overflow, beat count) over a valid/ready output. It is the sequential, parametrised successor of the 4-bit combinational signed adder with overflow flag, and feeds downstream arithmetic pipelines that need wrap or clamp semantics.

Parameters:
WIDTH, 8, data and accumulator width in bits (>= 2)
CNT_W, 8, width of beat counter; counter saturates at all-ones

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  input beat valid
in_ready  output  1  block accepts a beat this cycle
in_data  input  WIDTH  signed beat value
in_last  input  1  beat is the last of its packet
sat_en  input  1  saturation mode for this beat (1 = clamp, 0 = wrap); sampled per accepted beat
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  signed packet sum
out_overflow  output  1  at least one step in the packet overflowed
out_beats  output  CNT_W  beats in packet, saturating

Behaviour:
- States: ACCUM, HOLD. Reset (rst=0, async): state=ACCUM, acc=0, first=1, sticky=0, cnt=0, out_valid=0, out_sum=0, out_overflow=0, out_beats=0.
- in_ready = (state==ACCUM) && rst; purely state-derived, never depends on in_valid.
- Beat accepted when in_valid && in_ready. Step operand a = first ? 0 : acc; b = in_data.
- Raw sum r = a + b modulo 2^WIDTH. Step overflow ovf = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
- sat_en=1 && ovf: result = max positive (0,1...1) if a,b non-negative, min negative (1,0...0) if negative. Otherwise result = r (wrap).
- acc <= result; sticky <= (first ? 0 : sticky) | ovf; cnt <= (first ? 1 : cnt+1 saturating at 2^CNT_W-1); first <= in_last.
- Wrap mode flags intermediate overflow even if final sum is numerically correct (e.g. 7,+1,-1 at WIDTH=4 -> sum 7, overflow 1).
- Accepted beat with in_last=1: out_sum/out_overflow/out_beats load the new values; out_valid=1 next cycle (latency 1 cycle from last beat); state -> HOLD.
- HOLD: in_ready=0; out_* held stable while out_valid && !out_ready. On out_valid && out_ready: out_valid=0 next cycle, state -> ACCUM. No same-cycle bypass: one idle input cycle per packet.
- Single-beat packet: out_sum = in_data, out_overflow=0, out_beats=1.
- in_valid during HOLD: ignored, beat must be held by source.
- Reset mid-packet or mid-HOLD: partial packet and pending result discarded; out_valid drops asynchronously.
- out_* outputs are registered; out_sum/out_beats retain last values when out_valid=0.

Decomposition:
- Package signed_stream_pkg: state enum (ACCUM, HOLD); functions sat_max(WIDTH), sat_min(WIDTH) or localparam equivalents.
- Sub-module signed_add_sat: combinational, parameter WIDTH; inputs a, b, sat_en; outputs sum, overflow. Instantiated once for the step adder; reusable stand-alone.

Test Plan (WIDTH=4, CNT_W=8):
- Packet 3, 2, 1(last), sat_en=0 -> out_sum=6, out_overflow=0, out_beats=3, out_valid high exactly 1 cycle after last beat.
- Wrap: 7, 1(last), sat_en=0 -> out_sum=-8 (4'b1000), out_overflow=1; also 7, 1, -1(last) -> out_sum=7, out_overflow=1.
- Saturate: 7, 1, 1(last), sat_en=1 -> out_sum=7, out_overflow=1; -8, -1(last) -> out_sum=-8, out_overflow=1.
- Backpressure: out_ready=0 for 5 cycles after result -> out_* stable, in_ready=0, offered beats not consumed; after handshake, next packet 2(last) -> out_sum=2, out_overflow=0 (sticky cleared).
- Reset: assert rst=0 after 2 beats of a packet -> out_valid=0, in_ready=0 during reset; after release, packet 5(last) -> out_sum=5, out_beats=1.
- Single-beat -8(last) -> out_sum=-8, out_overflow=0, out_beats=1; 300-beat packet of 0 -> out_beats=255 (saturated).
